// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
package riscv_mem_pkg;

  localparam logic [2:0] WHB_B  = 3'd0;
  localparam logic [2:0] WHB_H  = 3'd1;
  localparam logic [2:0] WHB_W  = 3'd2;
  localparam logic [2:0] WHB_BU = 3'd3;
  localparam logic [2:0] WHB_HU = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  // Codes outside the legal load/store set collapse to a word access.
  function automatic logic [2:0] norm_whb(input logic we, input logic [2:0] whb);
    logic [2:0] r;
    if (we) r = (whb > WHB_W) ? WHB_W : whb;
    else    r = (whb > WHB_HU) ? WHB_W : whb;
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] whb, input logic [1:0] lo);
    logic r;
    case (whb)
      WHB_H, WHB_HU: r = lo[0];
      WHB_W:         r = (lo != 2'b00);
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replication and load extraction/extension.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  whb,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [15:0] shifted;

  always_comb begin
    shifted   = 16'(rdata >> {addr, 3'b000});
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (whb)
      WHB_B: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      WHB_H: begin
        be        = 4'b0011 << addr;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      WHB_BU: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'd0, shifted[7:0]};
      end
      WHB_HU: begin
        be        = 4'b0011 << addr;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'd0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by instruction fetch and load/store, one transaction at a time.
// Optional misaligned-access trap: define MEM_ARB_MISALIGN_TRAP_EN.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_whb,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state;
  owner_t        owner;
  logic          flush_pend;
  logic [SW-1:0] streak;
  logic [AW-1:0] addr_q;
  logic [2:0]    whb_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic          req_q;
  logic          err_q;

  logic          if_win;
  logic [2:0]    d_whb_n;
  logic          d_mis;
  logic          gnt_ok;
  logic          resp;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_rdata;

  assign if_win  = if_req & (~d_req | (streak == SW'(MAX_D_STREAK)));
  assign d_whb_n = norm_whb(d_we, d_whb);
  assign gnt_ok  = (state == ISSUE) & mem_ready;
  assign resp    = (state == WAIT) & mem_rvalid;

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign d_mis = misaligned(d_whb_n, d_addr[1:0]);
  assign d_err = err_q;
`else
  assign d_mis = 1'b0;
  assign d_err = 1'b0;
`endif

  mem_lane_align u_align (
    .whb       (whb_q),
    .addr      (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // Grants and responses track the memory handshake in the same cycle.
  assign if_gnt    = gnt_ok & (owner == OWN_IF);
  assign d_gnt     = (gnt_ok & (owner == OWN_D)) | err_q;
  assign if_rvalid = resp & (owner == OWN_IF) & ~flush_pend & ~if_flush;
  assign d_rvalid  = resp & (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = (d_rvalid & ~we_q) ? al_rdata : 32'd0;

  assign mem_req   = req_q;
  assign mem_we    = req_q & we_q;
  assign mem_addr  = req_q ? {addr_q[AW-1:2], 2'b00} : '0;
  assign mem_be    = req_q ? (we_q ? al_be : 4'b1111) : 4'b0000;
  assign mem_wdata = (req_q & we_q) ? al_wdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      flush_pend <= 1'b0;
      streak     <= '0;
      addr_q     <= '0;
      whb_q      <= WHB_W;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;

      if (if_gnt) begin
        streak <= '0;
      end else if (d_gnt) begin
        if (!if_req) streak <= '0;
        else if (streak != SW'(MAX_D_STREAK)) streak <= streak + SW'(1);
      end

      if (resp) flush_pend <= 1'b0;
      else if (if_flush && owner == OWN_IF && state != IDLE) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          // Skip arbitration in the trap-pulse cycle while the requester still holds d_req.
          if (!err_q && (if_req || d_req)) begin
            if (if_win) begin
              owner   <= OWN_IF;
              addr_q  <= if_addr;
              we_q    <= 1'b0;
              whb_q   <= WHB_W;
              wdata_q <= 32'd0;
              req_q   <= 1'b1;
              state   <= ISSUE;
            end else begin
              owner   <= OWN_D;
              addr_q  <= d_addr;
              we_q    <= d_we;
              whb_q   <= d_whb_n;
              wdata_q <= d_wdata;
              if (d_mis) begin
                err_q <= 1'b1;
              end else begin
                req_q <= 1'b1;
                state <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            req_q <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, random vs byte-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_whb = 3'd0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // memory model state
  logic [31:0] mem_w [256];
  int          ready_delay = 0;
  int          rvalid_lat = 1;
  bit          pend = 0;
  int          lat_cnt = 0;
  int          stall = 0;
  logic [31:0] resp_w = 32'd0;

  // reference model: byte-addressed image of the same memory
  logic [7:0]  ref_b [1024];

  mem_port_arbiter #(.AW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_whb(d_whb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: ready after ready_delay stalled cycles, response rvalid_lat cycles after acceptance.
  always begin
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_ready  = 1'b0;
    if (rst) begin
      pend  = 0;
      stall = 0;
    end else begin
      if (pend) begin
        if (lat_cnt <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = resp_w;
          pend       = 0;
        end else begin
          lat_cnt--;
        end
      end
      if (mem_req && !pend) begin
        if (stall < ready_delay) begin
          stall++;
        end else begin
          mem_ready = 1'b1;
          stall     = 0;
          pend      = 1;
          lat_cnt   = rvalid_lat;
          if (mem_we) begin
            for (int k = 0; k < 4; k++)
              if (mem_be[k]) mem_w[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
            resp_w = 32'd0;
          end else begin
            resp_w = mem_w[mem_addr[9:2]];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic set_word(input int widx, input logic [31:0] w);
    mem_w[widx] = w;
    for (int k = 0; k < 4; k++) ref_b[4*widx + k] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] whb, input int a);
    int v;
    case (whb)
      3'd0, 3'd3: begin
        v = int'(ref_b[a]);
        if (whb == 3'd0 && v > 127) v -= 256;
      end
      3'd1, 3'd4: begin
        v = int'(ref_b[a]) + 256 * int'(ref_b[a+1]);
        if (whb == 3'd1 && v > 32767) v -= 65536;
      end
      default: return ref_word(a);
    endcase
    return 32'(v);
  endfunction

  task automatic d_txn(input logic we, input logic [2:0] whb, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int lat_g, output int lat_r, output logic [3:0] be,
                       output logic [31:0] mwd, output logic [31:0] maddr,
                       output int req_cycles, output logic unstable);
    int c0;
    bit got_g;
    bit done;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = we; d_whb = whb; d_addr = addr; d_wdata = wdata;
    c0 = cyc; rdata = 32'd0; err = 1'b0; lat_g = -1; lat_r = -1;
    be = 4'd0; mwd = 32'd0; maddr = 32'd0; req_cycles = 0; unstable = 1'b0;
    got_g = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_req) begin
        if (req_cycles == 0) begin
          be = mem_be; mwd = mem_wdata; maddr = mem_addr;
        end else if ({mem_be, mem_wdata, mem_addr} !== {be, mwd, maddr}) begin
          unstable = 1'b1;
        end
        req_cycles++;
      end
      if (d_gnt && !got_g) begin
        got_g = 1; lat_g = cyc - c0; err = d_err;
        if (d_err) done = 1;
      end
      if (d_rvalid) begin
        rdata = d_rdata; lat_r = cyc - c0; done = 1;
      end
      @(posedge clk);
      #1;
      if (got_g) d_req = 1'b0;
    end
    d_req = 1'b0;
    check("d_txn_done", 32'(done), 32'd1);
  endtask

  task automatic if_txn(input logic [31:0] addr, output logic [31:0] rdata,
                        output int lat_g, output int lat_r);
    int c0;
    bit got_g;
    bit done;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = addr;
    c0 = cyc; rdata = 32'd0; lat_g = -1; lat_r = -1; got_g = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (if_gnt && !got_g) begin
        got_g = 1; lat_g = cyc - c0;
      end
      if (if_rvalid) begin
        rdata = if_rdata; lat_r = cyc - c0; done = 1;
      end
      @(posedge clk);
      #1;
      if (got_g) if_req = 1'b0;
    end
    if_req = 1'b0;
    check("if_txn_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  whb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] r, mwd, maddr, a, wd;
    logic [3:0]  be;
    logic        err, unst, we;
    logic [2:0]  whb;
    int          lg, lr, rc, k, size, n_if;
    bit          got, seen_mv, bad;

    vecs[0]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFF_FF80, 4'hF,    32'h0};
    vecs[1]  = '{1'b0, 3'd3, 32'h103, 32'h0,        32'h0000_0080, 4'hF,    32'h0};
    vecs[2]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'hFFFF_80FF, 4'hF,    32'h0};
    vecs[3]  = '{1'b0, 3'd4, 32'h100, 32'h0,        32'h0000_FF7F, 4'hF,    32'h0};
    vecs[4]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'h80FF_FF7F, 4'hF,    32'h0};
    vecs[5]  = '{1'b0, 3'd1, 32'h100, 32'h0,        32'hFFFF_FF7F, 4'hF,    32'h0};
    vecs[6]  = '{1'b1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h0,        4'b1100, 32'hBEEF_BEEF};
    vecs[7]  = '{1'b1, 3'd0, 32'h201, 32'h1234_5678, 32'h0,        4'b0010, 32'h7878_7878};
    vecs[8]  = '{1'b1, 3'd2, 32'h204, 32'hCAFE_F00D, 32'h0,        4'hF,    32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 3'd3, 32'h208, 32'h1122_3344, 32'h0,        4'hF,    32'h1122_3344};
    vecs[10] = '{1'b0, 3'd6, 32'h100, 32'h0,        32'h80FF_FF7F, 4'hF,    32'h0};

    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    set_word(32'h100 >> 2, 32'h80FF_FF7F);
    set_word(32'h300 >> 2, 32'h0000_0013);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_req, mem_we, mem_be} != 0 ||
              if_rdata != 0 || d_rdata != 0 || mem_addr != 0 || mem_wdata != 0), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'({mem_req, d_gnt, if_gnt}), 32'd0);

    // table-driven single D transactions, immediate memory
    for (int i = 0; i < 11; i++) begin
      d_txn(vecs[i].we, vecs[i].whb, vecs[i].addr, vecs[i].wdata, r, err, lg, lr, be, mwd, maddr, rc, unst);
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_be", i), 32'(be), 32'(vecs[i].exp_be));
      check($sformatf("vec%0d_addr", i), maddr, vecs[i].addr & 32'hFFFF_FFFC);
      check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
      check($sformatf("vec%0d_gnt_lat", i), 32'(lg), 32'd1);
      check($sformatf("vec%0d_rv_lat", i), 32'(lr), 32'd2);
      if (vecs[i].we) check($sformatf("vec%0d_wdata", i), mwd, vecs[i].exp_mwd);
    end

    // misaligned word load
    d_txn(1'b0, 3'd2, 32'h101, 32'h0, r, err, lg, lr, be, mwd, maddr, rc, unst);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    check("mis_err", 32'(err), 32'd1);
    check("mis_gnt_lat", 32'(lg), 32'd1);
    check("mis_no_memreq", 32'(rc), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req || d_rvalid || d_err || d_gnt) bad = 1;
    end
    check("mis_quiet_after", 32'(bad), 32'd0);
`else
    check("mis_err", 32'(err), 32'd0);
    check("mis_memreq", 32'(rc > 0), 32'd1);
    check("mis_addr", maddr, 32'h100);
    check("mis_rdata", r, 32'h80FF_FF7F);
`endif

    // memory not ready for 5 cycles
    ready_delay = 5;
    d_txn(1'b1, 3'd2, 32'h20C, 32'hA5A5_5A5A, r, err, lg, lr, be, mwd, maddr, rc, unst);
    check("stall_gnt_lat", 32'(lg), 32'd6);
    check("stall_req_cycles", 32'(rc), 32'd6);
    check("stall_stable", 32'(unst), 32'd0);
    check("stall_wdata", mwd, 32'hA5A5_5A5A);
    ready_delay = 0;

    // flush an in-flight fetch
    rvalid_lat = 4;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h300;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_gnt) got = 1;
      @(posedge clk);
      #1;
    end
    check("flush_gnt_seen", 32'(got), 32'd1);
    if_req = 1'b0; if_flush = 1'b1;
    seen_mv = 0; n_if = 0;
    for (int i = 0; i < 20 && !seen_mv; i++) begin
      @(negedge clk);
      if (if_rvalid) n_if++;
      if (mem_rvalid) seen_mv = 1;
      @(posedge clk);
      #1;
      if_flush = 1'b0;
    end
    check("flush_mem_resp", 32'(seen_mv), 32'd1);
    check("flush_suppressed", 32'(n_if), 32'd0);
    rvalid_lat = 1;
    if_txn(32'h300, r, lg, lr);
    check("fetch_after_flush", r, 32'h0000_0013);
    check("fetch_gnt_lat", 32'(lg), 32'd1);
    check("fetch_rv_lat", 32'(lr), 32'd2);

    // starvation guard: both requesters always asking
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_whb = 3'd2; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h300;
    k = 0;
    for (int i = 0; i < 80 && k < 10; i++) begin
      @(negedge clk);
      if (d_gnt || if_gnt) begin
        check($sformatf("starve_grant%0d_is_if", k), 32'(if_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
        k++;
      end
    end
    check("starve_grants", 32'(k), 32'd10);
    @(posedge clk);
    #1;
    d_req = 1'b0; if_req = 1'b0;
    repeat (6) @(posedge clk);

    // random traffic against the byte-level reference
    for (int t = 0; t < 40; t++) begin
      ready_delay = $urandom_range(0, 2);
      rvalid_lat  = $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) begin
        a = 32'($urandom_range(0, 63)) * 4;
        if_txn(a, r, lg, lr);
        check("rnd_fetch", r, ref_word(int'(a)));
      end else begin
        we   = 1'($urandom_range(0, 1));
        whb  = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
        size = (whb == 3'd0 || whb == 3'd3) ? 1 : (whb == 3'd1 || whb == 3'd4) ? 2 : 4;
        a    = 32'(($urandom_range(0, 255) / size) * size);
        wd   = $urandom;
        d_txn(we, whb, a, wd, r, err, lg, lr, be, mwd, maddr, rc, unst);
        if (we) begin
          for (int b = 0; b < size; b++) ref_b[int'(a) + b] = wd[8*b +: 8];
          check("rnd_store_rdata", r, 32'd0);
        end else begin
          check("rnd_load", r, ref_load(whb, int'(a)));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
